ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite responder that backs a word-organised register-file memory and answers the master-side signals defined in `AHB_package` (htrans, hsize, hburst encodings). It sits behind the address decoder on the slave side of the interconnect. It accepts pipelined address/data phases, inserts a programmable number of wait states, and performs byte/halfword/word reads and writes. It optionally signals protocol errors with the two-cycle ERROR response.

## Interface
- MEM_DEPTH, 256: number of 32-bit words; power of two, 4..4096.
- WAIT_STATES, 0: wait cycles inserted in each data phase with hreadyout=0; range 0..7.
- hclk  in  1  bus clock; all state updates on the rising edge.
- hresetn  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select from the decoder.
- haddr  in  32  byte address; word index = haddr[log2(MEM_DEPTH)+1:2]; upper bits ignored (alias).
- hwrite  in  1  1 = write, 0 = read.
- hsize  in  3  hsize_type encoding.
- hburst  in  3  hburst_type encoding; ignored (every beat carries its own address).
- hprot  in  4  ignored.
- htrans  in  2  htrans_type encoding.
- hmastlock  in  1  ignored.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-level ready; an address phase is sampled only when it is 1.
- hreadyout  out  1  slave ready; reset value 1.
- hresp  out  1  0 = OKAY, 1 = ERROR; reset value 0.
- hrdata  out  32  read data; reset value 0.

## Operation
- Transfer accept: on an edge with hsel=1, hready=1 and htrans∈{NONSEQ,SEQ}, capture the word index, haddr[1:0], hwrite and hsize, then enter the data phase.
- IDLE or BUSY, hsel=0, or hready=0: nothing is captured. The next cycle shows hreadyout=1, hresp=0 and no memory access.
- States:
  - IDLE: no pending data phase.
  - WAIT: the counter counts down from WAIT_STATES; hreadyout=0.
  - DONE: hreadyout=1, hresp=0; the transfer completes at the end of this cycle.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- Transitions:
  - Accept goes to WAIT if WAIT_STATES>0, otherwise to DONE.
  - WAIT goes to DONE when the counter reaches 1.
  - DONE or ERR2, with a new accept on the same edge: go to WAIT, DONE or ERR1 as for a fresh accept (back-to-back pipelining).
  - DONE or ERR2, with no accept: go to IDLE.
- Write: commits on the DONE→next edge. Byte lanes are enabled by size and address:
  - BYTE: lane haddr[1:0].
  - HALFWORD: lanes 1:0 when haddr[1]=0, lanes 3:2 when haddr[1]=1.
  - WORD: all four lanes.
  - Unselected bytes are unchanged.
- Read: hrdata = mem[captured index] combinationally, for the whole read data phase (WAIT and DONE). The full word is returned; the master selects its lanes. hrdata=0 in every other state.
- Read after write to the same word: the write commits before the read's data phase, so the new value is returned with no forwarding.
- Memory contents are not reset.

## Timing
- Zero-wait latency: address phase at edge N; data phase is cycle N..N+1 with hreadyout=1; write commits and read data is sampled at edge N+1.
- WAIT_STATES=k: hreadyout is low for k cycles, then high for one cycle.
- Address inputs are not sampled while hreadyout=0.
- ERROR: exactly two cycles (ERR1 then ERR2). The address sampled on the ERR2 edge is accepted normally, even if the master did not cancel.
- Reset asserted mid-transfer: immediately returns to IDLE with hreadyout=1, hresp=0, hrdata=0; a pending write is dropped.

## Configuration
- AHB_SLV_ERR_CHECK_EN defined: an accepted transfer is illegal if any of these hold:
  - hsize > WORD;
  - HALFWORD with haddr[0]=1;
  - WORD with haddr[1:0]≠0.
  - An illegal transfer goes to ERR1 instead of WAIT/DONE, skips wait states and never writes memory.
- Undefined: no check is made and ERR1/ERR2 are unreachable. Illegal sizes are treated as WORD, and misaligned addresses use lanes from haddr[1] (halfword) or all lanes (word); hresp stays 0.

## Test plan
- Reset: hresetn=0 → hreadyout=1, hresp=0, hrdata=0; release, IDLE on htrans → no change.
- WAIT_STATES=0: NONSEQ write WORD 0x10 = 0xDEADBEEF, then NONSEQ read 0x10 back-to-back → hreadyout stays 1; hrdata=0xDEADBEEF in the read data phase.
- Byte write 0xAA to 0x13 over 0x11223344 → read gives 0xAA223344; halfword write 0x5566 to 0x12 → read gives 0x55663344.
- WAIT_STATES=3: INCR4 burst (NONSEQ + 3 SEQ, one BUSY inserted) → each beat has 3 low hreadyout cycles; BUSY gives a one-cycle OKAY with no access; all four words written.
- With AHB_SLV_ERR_CHECK_EN: WORD read at 0x02 → ERR1 (hreadyout=0, hresp=1), ERR2 (1,1), memory unchanged; a following NONSEQ accepted at the ERR2 edge completes OKAY.
- hresetn pulsed low during the 2nd wait cycle of a write → outputs return to reset values; target word unchanged.

Source files
------------

// File: rtl/ahb_sram_slave.sv
//-----------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB-Lite responder in front of a word-organised register-file memory.
// Accepts pipelined address/data phases, inserts WAIT_STATES wait cycles into
// every data phase and performs byte/halfword/word writes. Reads always return
// the full addressed word; the master picks its byte lanes.
//
// Optional feature macro: AHB_SLV_ERR_CHECK_EN
//   defined   : illegal size/alignment combinations get the two-cycle ERROR
//               response (ERR1, ERR2), skip wait states and never write.
//   undefined : no checking; oversized hsize behaves as WORD, misaligned
//               halfwords use haddr[1] for lane selection, hresp stays 0.
//
// Handshake: an address phase is taken on a rising edge where hsel=1,
// hready=1, htrans is NONSEQ or SEQ and this slave is itself ready
// (hreadyout=1). The data phase then ends on the first rising edge at which
// hreadyout=1; write data is committed and read data is sampled on that edge.
//
// Parameters:
//   MEM_DEPTH    number of 32-bit words (power of two, 4..4096)
//   WAIT_STATES  wait cycles per data phase (0..7)
//
// Ports:
//   hclk, hresetn      clock, asynchronous active-low reset
//   hsel               slave select from the address decoder
//   haddr              byte address; word index haddr[log2(MEM_DEPTH)+1:2]
//   hwrite, hsize      direction and transfer size
//   hburst, hprot,
//   hmastlock          accepted but unused
//   htrans             transfer type
//   hwdata             write data (data phase)
//   hready             bus-level ready
//   hreadyout          slave ready (1 out of reset)
//   hresp              0 = OKAY, 1 = ERROR (0 out of reset)
//   hrdata             read data (0 out of reset and outside read phases)
//   dbg_state          current FSM state, for observation only
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ahb_sram_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
`ifdef AHB_SLV_ERR_CHECK_EN
  localparam logic [2:0] HSIZE_WORD = 3'b010;
`endif

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    st_idle = 3'd0,
    st_wait = 3'd1,
    st_done = 3'd2,
    st_err1 = 3'd3,
    st_err2 = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [1:0]    lo_q;
  logic          wr_q;
  logic [2:0]    size_q;

  logic          accept;
  logic          start;
  logic          illegal;
  logic [3:0]    be;

  logic [31:0]   mem [MEM_DEPTH];

  // hburst, hprot, hmastlock and the aliased upper address bits carry no
  // meaning for this memory.
  logic unused_inputs;
  assign unused_inputs = ^{hburst, hprot, hmastlock, haddr[31:AW+2]};

  //---------------------------------------------------------------------------
  // Address phase
  //---------------------------------------------------------------------------
  // NONSEQ (2'b10) and SEQ (2'b11) are the only types with bit 1 set; IDLE and
  // BUSY never start a data phase. Gating with hreadyout keeps the address
  // inputs ignored while our own data phase is stalled.
  assign accept = hsel & hready & htrans[1] & hreadyout;

`ifdef AHB_SLV_ERR_CHECK_EN
  assign illegal = (hsize > HSIZE_WORD) ||
                   ((hsize == HSIZE_HALF) && haddr[0]) ||
                   ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
`else
  assign illegal = 1'b0;
`endif

  //---------------------------------------------------------------------------
  // FSM: state register
  //---------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= st_idle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  //---------------------------------------------------------------------------
  // FSM: next state
  //---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;

    unique case (state_q)
      st_idle: begin
        start = accept;
      end
      st_wait: begin
        if (cnt_q == 3'd1) begin
          state_d = st_done;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      // Last cycle of a response: a new address may be taken on the same edge.
      st_done, st_err2: begin
        state_d = st_idle;
        start   = accept;
      end
      st_err1: begin
        state_d = st_err2;
      end
      default: begin
        state_d = st_idle;
      end
    endcase

    if (start) begin
      if (illegal) begin
        state_d = st_err1;
      end else if (WAIT_STATES > 0) begin
        state_d = st_wait;
        cnt_d   = WAIT_LOAD;
      end else begin
        state_d = st_done;
      end
    end
  end

  //---------------------------------------------------------------------------
  // Captured address-phase control
  //---------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      idx_q  <= '0;
      lo_q   <= 2'b00;
      wr_q   <= 1'b0;
      size_q <= 3'b000;
    end else if (start) begin
      idx_q  <= haddr[AW+1:2];
      lo_q   <= haddr[1:0];
      wr_q   <= hwrite;
      size_q <= hsize;
    end
  end

  //---------------------------------------------------------------------------
  // Byte-lane enables. Any size other than BYTE/HALF acts as a full word,
  // which also covers oversized hsize when checking is off.
  //---------------------------------------------------------------------------
  always_comb begin
    be = 4'b0000;
    if (size_q == HSIZE_BYTE) begin
      be = 4'b0001 << lo_q;
    end else if (size_q == HSIZE_HALF) begin
      be = lo_q[1] ? 4'b1100 : 4'b0011;
    end else begin
      be = 4'b1111;
    end
  end

  //---------------------------------------------------------------------------
  // Memory (not reset). The write lands on the edge that ends DONE; a reset
  // during WAIT forces st_idle first, so the pending write is dropped.
  //---------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    if ((state_q == st_done) && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  //---------------------------------------------------------------------------
  // Outputs
  //---------------------------------------------------------------------------
  assign hreadyout = !((state_q == st_wait) || (state_q == st_err1));
  assign hresp     = (state_q == st_err1) || (state_q == st_err2);

  // Reads need no forwarding: an earlier write has already committed by the
  // time a following read's data phase begins.
  assign hrdata = (!wr_q && ((state_q == st_wait) || (state_q == st_done)))
                  ? mem[idx_q] : 32'h0000_0000;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
`timescale 1ns/1ps

module tb_ahb_sram_slave;

  localparam int DEPTH = 16;
  localparam int WS    = 3;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  //---------------------------------------------------------------------------
  // Clock / reset / DUT
  //---------------------------------------------------------------------------
  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic [2:0]  dbg_state;

  always #5 hclk = ~hclk;

  // Single-slave bus: the bus-level ready is this slave's ready.
  assign hready = hreadyout;

  ahb_sram_slave #(
    .MEM_DEPTH  (DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hsel     (hsel),
    .haddr    (haddr),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hburst   (hburst),
    .hprot    (hprot),
    .htrans   (htrans),
    .hmastlock(hmastlock),
    .hwdata   (hwdata),
    .hready   (hready),
    .hreadyout(hreadyout),
    .hresp    (hresp),
    .hrdata   (hrdata),
    .dbg_state(dbg_state)
  );

  //---------------------------------------------------------------------------
  // Scoreboard state and reference model
  //---------------------------------------------------------------------------
  // Entry: {error, is_read, read_data}
  logic [33:0] exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_illegal(input logic [2:0] sz, input logic [31:0] a);
`ifdef AHB_SLV_ERR_CHECK_EN
    return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] lane_mask(input logic [2:0] sz, input logic [31:0] a);
    if (sz == 3'd0) return 32'h0000_00FF << (8 * (a % 4));
    if (sz == 3'd1) return 32'h0000_FFFF << (16 * ((a / 2) % 2));
    return 32'hFFFF_FFFF;
  endfunction

  // Called once per accepted transfer, in bus order.
  task automatic model_issue(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] wd);
    int          idx;
    logic [31:0] m;
    idx = int'((a / 4) % DEPTH);
    if (is_illegal(sz, a)) begin
      exp_q.push_back({1'b1, !wr, 32'h0});
    end else if (wr) begin
      m = lane_mask(sz, a);
      ref_mem[idx] = (ref_mem[idx] & ~m) | (wd & m);
      exp_q.push_back({1'b0, 1'b0, 32'h0});
    end else begin
      exp_q.push_back({1'b0, 1'b1, ref_mem[idx]});
    end
  endtask

  //---------------------------------------------------------------------------
  // Driver tasks (called just after a rising edge)
  //---------------------------------------------------------------------------
  // Advance to the next rising edge at which hready is high.
  task automatic wait_edge_ready(input string who);
    int   n;
    logic r;
    n = 0;
    forever begin
      @(negedge hclk);
      r = hready;
      @(posedge hclk);
      if (r === 1'b1) break;
      n++;
      if (n > 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s ready timeout: actual no-ready required ready at %0t", who, $time);
        break;
      end
    end
    #1;
  endtask

  task automatic drive_beat(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
    hsel   = 1'b1;
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
    wait_edge_ready("beat");
    model_issue(wr, sz, a, wd);
    hwdata = wd;
  endtask

  task automatic drive_nop(input logic [1:0] tr, input logic sel);
    hsel   = sel;
    htrans = tr;
    haddr  = $urandom;
    hwrite = 1'($urandom_range(0, 1));
    wait_edge_ready("nop");
  endtask

  task automatic wait_drain(input string who);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge hclk);
      n++;
    end
    #1;
    chk(who, 32'(exp_q.size()), 32'd0);
  endtask

  //---------------------------------------------------------------------------
  // Monitor: tracks data phases from the bus and compares on completion
  //---------------------------------------------------------------------------
  initial begin : monitor
    logic        r, resp, acc, pend, lo_or, lo_and;
    logic [31:0] rd;
    logic [33:0] e;
    int          low;
    pend = 1'b0; low = 0; lo_or = 1'b0; lo_and = 1'b1;
    forever begin
      @(negedge hclk);
      r    = hreadyout;
      resp = hresp;
      rd   = hrdata;
      acc  = hsel & htrans[1];
      if (!mon_en) begin
        pend = 1'b0; low = 0; lo_or = 1'b0; lo_and = 1'b1;
      end else if (pend) begin
        if (!r) begin
          low++;
          lo_or  = lo_or | resp;
          lo_and = lo_and & resp;
        end
      end else begin
        chk("idle hreadyout", 32'(r), 32'd1);
        chk("idle hresp", 32'(resp), 32'd0);
        chk("idle hrdata", rd, 32'd0);
      end
      @(posedge hclk);
      if (mon_en && r) begin
        if (pend) begin
          if (exp_q.size() == 0) begin
            chk("unexpected completion", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (e[33]) begin
              chk("error hresp", 32'(resp), 32'd1);
              chk("error low cycles", 32'(low), 32'd1);
              chk("error first-cycle hresp", 32'(lo_and), 32'd1);
            end else begin
              chk("okay hresp", 32'(resp), 32'd0);
              chk("wait cycles", 32'(low), 32'(WS));
              chk("wait hresp", 32'(lo_or), 32'd0);
              if (e[32]) chk("read data", rd, e[31:0]);
            end
          end
          low = 0; lo_or = 1'b0; lo_and = 1'b1;
        end
        pend = acc;
      end
    end
  end

  //---------------------------------------------------------------------------
  // Watchdog
  //---------------------------------------------------------------------------
  initial begin : watchdog
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: actual still running required finished at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  //---------------------------------------------------------------------------
  // Stimulus
  //---------------------------------------------------------------------------
  initial begin : stimulus
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic [31:0] a;
    int          kind;

    hresetn = 1'b0; hsel = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; hprot = 4'b0011; htrans = T_IDLE; hmastlock = 1'b0; hwdata = '0;

    // Reset values
    #12;
    chk("reset hreadyout", 32'(hreadyout), 32'd1);
    chk("reset hresp", 32'(hresp), 32'd0);
    chk("reset hrdata", hrdata, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    mon_en = 1'b1;

    // IDLE / deselected cycles: no change
    drive_nop(T_IDLE, 1'b1);
    drive_nop(T_NONSEQ, 1'b0);
    drive_nop(T_IDLE, 1'b1);

    // Fill every word so later reads have defined contents
    for (int i = 0; i < DEPTH; i++) drive_beat(T_NONSEQ, 1'b1, 3'd2, 32'(i * 4), $urandom);
    drive_nop(T_IDLE, 1'b1);

    // Word write then back-to-back read
    drive_beat(T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    drive_beat(T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    drive_nop(T_IDLE, 1'b1);

    // Byte and halfword merges
    drive_beat(T_NONSEQ, 1'b1, 3'd2, 32'h10, 32'h1122_3344);
    drive_beat(T_NONSEQ, 1'b1, 3'd0, 32'h13, 32'hAA00_0000);
    drive_beat(T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    drive_beat(T_NONSEQ, 1'b1, 3'd1, 32'h12, 32'h5566_0000);
    drive_beat(T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    drive_nop(T_IDLE, 1'b1);

    // INCR4 burst with a BUSY, then read all four beats back
    hburst = 3'b011;
    drive_beat(T_NONSEQ, 1'b1, 3'd2, 32'h20, 32'hA0A0_0001);
    drive_beat(T_SEQ,    1'b1, 3'd2, 32'h24, 32'hA0A0_0002);
    drive_nop(T_BUSY, 1'b1);
    drive_beat(T_SEQ,    1'b1, 3'd2, 32'h28, 32'hA0A0_0003);
    drive_beat(T_SEQ,    1'b1, 3'd2, 32'h2C, 32'hA0A0_0004);
    drive_beat(T_NONSEQ, 1'b0, 3'd2, 32'h20, 32'h0);
    drive_beat(T_SEQ,    1'b0, 3'd2, 32'h24, 32'h0);
    drive_beat(T_SEQ,    1'b0, 3'd2, 32'h28, 32'h0);
    drive_beat(T_SEQ,    1'b0, 3'd2, 32'h2C, 32'h0);
    hburst = 3'b000;
    drive_nop(T_IDLE, 1'b1);

    // Misaligned / oversized transfers (ERROR when checking is built in)
    drive_beat(T_NONSEQ, 1'b0, 3'd2, 32'h02, 32'h0);
    drive_beat(T_NONSEQ, 1'b0, 3'd2, 32'h00, 32'h0);
    drive_beat(T_NONSEQ, 1'b1, 3'd2, 32'h06, 32'h1357_9BDF);
    drive_beat(T_NONSEQ, 1'b1, 3'd1, 32'h09, 32'h2468_ACE0);
    drive_beat(T_NONSEQ, 1'b1, 3'd3, 32'h0C, 32'hFEED_FACE);
    drive_beat(T_NONSEQ, 1'b0, 3'd2, 32'h04, 32'h0);
    drive_beat(T_NONSEQ, 1'b0, 3'd2, 32'h08, 32'h0);
    drive_beat(T_NONSEQ, 1'b0, 3'd2, 32'h0C, 32'h0);
    drive_nop(T_IDLE, 1'b1);

    // Randomized traffic with aliasing addresses
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 11);
      if (kind == 0) begin
        drive_nop(T_IDLE, 1'b1);
      end else if (kind == 1) begin
        drive_nop(T_BUSY, 1'b1);
      end else if (kind == 2) begin
        drive_nop(T_NONSEQ, 1'b0);
      end else begin
        tr = ($urandom_range(0, 1) != 0) ? T_SEQ : T_NONSEQ;
        sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        a  = $urandom;
        if ($urandom_range(0, 1) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
        drive_beat(tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
      end
    end
    drive_nop(T_IDLE, 1'b1);
    wait_drain("drain before reset test");

    // Reset during the 2nd wait cycle of a write: write must be dropped
    drive_beat(T_NONSEQ, 1'b1, 3'd2, 32'h34, 32'hCAFE_F00D);
    drive_nop(T_IDLE, 1'b1);
    wait_drain("drain before abort");
    mon_en = 1'b0;
    hsel = 1'b1; htrans = T_NONSEQ; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h34;
    wait_edge_ready("abort");
    hwdata = 32'h0BAD_0BAD;
    htrans = T_IDLE;
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b0;
    #1;
    chk("mid reset hreadyout", 32'(hreadyout), 32'd1);
    chk("mid reset hresp", 32'(hresp), 32'd0);
    chk("mid reset hrdata", hrdata, 32'd0);
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    mon_en = 1'b1;
    drive_beat(T_NONSEQ, 1'b0, 3'd2, 32'h34, 32'h0);
    drive_beat(T_NONSEQ, 1'b0, 3'd2, 32'h10, 32'h0);
    drive_nop(T_IDLE, 1'b1);
    wait_drain("final drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
